// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline-control source for the five-stage core. It produces the 2-bit mode
// word {stall, flush} for the PC and for each pipeline register (IF_ID,
// ID_EXE, EXE_MEM, MEM_WB). It resolves three hazards in priority order:
// data-memory wait, taken branch in EXE, and load-use between EXE and ID.
// It also contains a memory-wait watchdog and optional stall/flush counters.
//
// Mode word: bit[1] = stall (hold register), bit[0] = flush (load zeros).
// This block never drives 2'b11.
//
// Build option:
//   HAZARD_PERF_CNT_EN  defined   -> stall_cnt_o / flush_cnt_o count cycles
//                       undefined -> no counter flops, both outputs are 0
//
// Ports:
//   clk_i               core clock
//   rst_ni              synchronous active-low reset
//   id_rs1_addr_i/re_i  ID-stage rs1 address / read enable
//   id_rs2_addr_i/re_i  ID-stage rs2 address / read enable
//   exe_rd_addr_i       EXE-stage destination register
//   exe_rd_we_i         EXE-stage instruction writes rd
//   exe_mem_re_i        EXE-stage instruction is a load
//   exe_branch_taken_i  EXE-stage control transfer redirects the PC
//   dmem_busy_i         MEM-stage access not yet complete
//   pc_mode_o           mode word for the PC
//   if_id_mode_o        mode word for IF_ID
//   id_exe_mode_o       mode word for ID_EXE
//   exe_mem_mode_o      mode word for EXE_MEM
//   mem_wb_mode_o       mode word for MEM_WB
//   mem_timeout_o       sticky watchdog flag, cleared only by reset
//   stall_cnt_o         cycles with pc_mode_o[1] set
//   flush_cnt_o         cycles in which a branch flush was issued
//
// State table:
//   state       | meaning
//   ST_RUN      | no memory wait in progress
//   ST_MEM_WAIT | data memory reported busy on the previous edge
// -----------------------------------------------------------------------------

`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 4:0
`endif

module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [`GPR_ADDR_SPACE]  id_rs1_addr_i,
   input  logic                    id_rs1_re_i,
   input  logic [`GPR_ADDR_SPACE]  id_rs2_addr_i,
   input  logic                    id_rs2_re_i,
   input  logic [`GPR_ADDR_SPACE]  exe_rd_addr_i,
   input  logic                    exe_rd_we_i,
   input  logic                    exe_mem_re_i,
   input  logic                    exe_branch_taken_i,
   input  logic                    dmem_busy_i,
   output logic [1:0]              pc_mode_o,
   output logic [1:0]              if_id_mode_o,
   output logic [1:0]              id_exe_mode_o,
   output logic [1:0]              exe_mem_mode_o,
   output logic [1:0]              mem_wb_mode_o,
   output logic                    mem_timeout_o,
   output logic [CNT_WIDTH-1:0]    stall_cnt_o,
   output logic [CNT_WIDTH-1:0]    flush_cnt_o
);

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   localparam int unsigned    WCW         = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] TIMEOUT_VAL = WCW'(MEM_TIMEOUT);

   localparam logic [1:0] MODE_RUN   = 2'b00;
   localparam logic [1:0] MODE_FLUSH = 2'b01;
   localparam logic [1:0] MODE_STALL = 2'b10;

   state_t           r_state;
   logic [WCW-1:0]   r_wait_cnt;
   logic             r_mem_timeout;

   logic [WCW-1:0]   w_wait_nxt;
   logic             w_rs1_hit;
   logic             w_rs2_hit;
   logic             w_load_use;
   logic [1:0]       w_pc_mode;
   logic [1:0]       w_if_id_mode;
   logic [1:0]       w_id_exe_mode;
   logic [1:0]       w_exe_mem_mode;
   logic [1:0]       w_mem_wb_mode;

   // ---------------------------------------------------------------------------
   // Load-use detection. A write to x0 is architecturally discarded, so it can
   // never create a dependency.
   // ---------------------------------------------------------------------------
   assign w_rs1_hit  = id_rs1_re_i & (id_rs1_addr_i == exe_rd_addr_i);
   assign w_rs2_hit  = id_rs2_re_i & (id_rs2_addr_i == exe_rd_addr_i);
   assign w_load_use = exe_mem_re_i & exe_rd_we_i
                     & (exe_rd_addr_i != '0)
                     & (w_rs1_hit | w_rs2_hit);

   // ---------------------------------------------------------------------------
   // Mode decode. Combinational so a stall lands in the same cycle busy rises.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_pc_mode      = MODE_RUN;
      w_if_id_mode   = MODE_RUN;
      w_id_exe_mode  = MODE_RUN;
      w_exe_mem_mode = MODE_RUN;
      w_mem_wb_mode  = MODE_RUN;
      if (!rst_ni) begin
         // Fill the pipe with bubbles while reset is held; PC loads its vector.
         w_if_id_mode   = MODE_FLUSH;
         w_id_exe_mode  = MODE_FLUSH;
         w_exe_mem_mode = MODE_FLUSH;
         w_mem_wb_mode  = MODE_FLUSH;
      end else if (dmem_busy_i) begin
         // Freeze everything up to MEM; WB gets a bubble so the retiring
         // instruction is not written twice. EXE is frozen, so a pending
         // branch or load-use is simply deferred.
         w_pc_mode      = MODE_STALL;
         w_if_id_mode   = MODE_STALL;
         w_id_exe_mode  = MODE_STALL;
         w_exe_mem_mode = MODE_STALL;
         w_mem_wb_mode  = MODE_FLUSH;
      end else if (exe_branch_taken_i) begin
         // ID is wrong-path, so any load-use it shows is irrelevant.
         w_if_id_mode   = MODE_FLUSH;
         w_id_exe_mode  = MODE_FLUSH;
      end else if (w_load_use) begin
         // One bubble: next cycle EXE holds the bubble and the hit clears.
         w_pc_mode      = MODE_STALL;
         w_if_id_mode   = MODE_STALL;
         w_id_exe_mode  = MODE_FLUSH;
      end
   end

   assign pc_mode_o      = w_pc_mode;
   assign if_id_mode_o   = w_if_id_mode;
   assign id_exe_mode_o  = w_id_exe_mode;
   assign exe_mem_mode_o = w_exe_mem_mode;
   assign mem_wb_mode_o  = w_mem_wb_mode;

   // ---------------------------------------------------------------------------
   // Watchdog count of consecutive busy cycles. The RUN cycle in which busy
   // first rises is itself a busy cycle, so the count starts at 1 there; any
   // cycle with busy low restarts the run from zero.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_wait_nxt = '0;
      if (dmem_busy_i) begin
         if (r_state == ST_RUN) begin
            w_wait_nxt = WCW'(1);
         end else if (r_wait_cnt != TIMEOUT_VAL) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
         end else begin
            w_wait_nxt = r_wait_cnt;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Memory-wait FSM and watchdog. Reset aborts an in-progress wait; if busy
   // is still high after release the FSM re-enters MEM_WAIT on the next edge.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state       <= ST_RUN;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_wait_cnt <= w_wait_nxt;
         // Sticky: only reset clears it, and it never feeds back into the stall.
         if (w_wait_nxt == TIMEOUT_VAL) begin
            r_mem_timeout <= 1'b1;
         end
         case (r_state)
            ST_RUN: begin
               if (dmem_busy_i) begin
                  r_state <= ST_MEM_WAIT;
               end
            end
            ST_MEM_WAIT: begin
               if (!dmem_busy_i) begin
                  r_state <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign mem_timeout_o = r_mem_timeout;

   // ---------------------------------------------------------------------------
   // Performance counters (wrap modulo 2^CNT_WIDTH).
   // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_flush_cnt;
   logic                 w_branch_flush;

   // Mirrors the branch arm of the decode: a branch shadowed by busy is not
   // a flush yet.
   assign w_branch_flush = rst_ni & ~dmem_busy_i & exe_branch_taken_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_pc_mode[1]) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_branch_flush) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign flush_cnt_o = r_flush_cnt;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   logic        clk_i;
   logic        rst_ni;
   logic [4:0]  id_rs1_addr_i;
   logic        id_rs1_re_i;
   logic [4:0]  id_rs2_addr_i;
   logic        id_rs2_re_i;
   logic [4:0]  exe_rd_addr_i;
   logic        exe_rd_we_i;
   logic        exe_mem_re_i;
   logic        exe_branch_taken_i;
   logic        dmem_busy_i;
   logic [1:0]  pc_mode_o;
   logic [1:0]  if_id_mode_o;
   logic [1:0]  id_exe_mode_o;
   logic [1:0]  exe_mem_mode_o;
   logic [1:0]  mem_wb_mode_o;
   logic        mem_timeout_o;
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;

   hazard_ctrl #(
      .MEM_TIMEOUT (4),
      .CNT_WIDTH   (32)
   ) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .id_rs1_addr_i      (id_rs1_addr_i),
      .id_rs1_re_i        (id_rs1_re_i),
      .id_rs2_addr_i      (id_rs2_addr_i),
      .id_rs2_re_i        (id_rs2_re_i),
      .exe_rd_addr_i      (exe_rd_addr_i),
      .exe_rd_we_i        (exe_rd_we_i),
      .exe_mem_re_i       (exe_mem_re_i),
      .exe_branch_taken_i (exe_branch_taken_i),
      .dmem_busy_i        (dmem_busy_i),
      .pc_mode_o          (pc_mode_o),
      .if_id_mode_o       (if_id_mode_o),
      .id_exe_mode_o      (id_exe_mode_o),
      .exe_mem_mode_o     (exe_mem_mode_o),
      .mem_wb_mode_o      (mem_wb_mode_o),
      .mem_timeout_o      (mem_timeout_o),
      .stall_cnt_o        (stall_cnt_o),
      .flush_cnt_o        (flush_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Expected modes packed as {pc, if_id, id_exe, exe_mem, mem_wb}.
   localparam logic [9:0] M_IDLE = 10'b00_00_00_00_00;
   localparam logic [9:0] M_RST  = 10'b00_01_01_01_01;
   localparam logic [9:0] M_LU   = 10'b10_10_01_00_00;
   localparam logic [9:0] M_BR   = 10'b00_01_01_00_00;
   localparam logic [9:0] M_MW   = 10'b10_10_10_10_01;

   typedef struct {
      string       name;
      logic        rst_n;
      logic [4:0]  rs1;
      logic        re1;
      logic [4:0]  rs2;
      logic        re2;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic        br;
      logic        busy;
      logic [9:0]  modes;
      logic        to;
      int unsigned stall;
      int unsigned flush;
      logic        chk_regs;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   int n_vec = 0;
   int n_miss = 0;

   task automatic add(input string name, input logic rst_n,
                      input logic [4:0] rs1, input logic re1,
                      input logic [4:0] rs2, input logic re2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic br, input logic busy, input logic [9:0] modes,
                      input logic to, input int unsigned s, input int unsigned f,
                      input logic chk);
      vec_t v;
      v.name = name; v.rst_n = rst_n;
      v.rs1 = rs1; v.re1 = re1; v.rs2 = rs2; v.re2 = re2;
      v.rd = rd; v.we = we; v.ld = ld; v.br = br; v.busy = busy;
      v.modes = modes; v.to = to; v.stall = s; v.flush = f; v.chk_regs = chk;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // Monitor: one scoreboard entry per cycle, compared on the falling edge.
   always @(negedge clk_i) begin
      if (sb.size() > 0) begin
         vec_t        e;
         logic [31:0] exp_s;
         logic [31:0] exp_f;
         e = sb.pop_front();
         n_vec++;
         check({e.name, ".pc"},      n_vec, 32'(pc_mode_o),      32'(e.modes[9:8]));
         check({e.name, ".if_id"},   n_vec, 32'(if_id_mode_o),   32'(e.modes[7:6]));
         check({e.name, ".id_exe"},  n_vec, 32'(id_exe_mode_o),  32'(e.modes[5:4]));
         check({e.name, ".exe_mem"}, n_vec, 32'(exe_mem_mode_o), 32'(e.modes[3:2]));
         check({e.name, ".mem_wb"},  n_vec, 32'(mem_wb_mode_o),  32'(e.modes[1:0]));
         if (e.chk_regs) begin
`ifdef HAZARD_PERF_CNT_EN
            exp_s = e.stall;
            exp_f = e.flush;
`else
            exp_s = 32'd0;
            exp_f = 32'd0;
`endif
            check({e.name, ".timeout"}, n_vec, 32'(mem_timeout_o), 32'(e.to));
            check({e.name, ".stall_cnt"}, n_vec, stall_cnt_o, exp_s);
            check({e.name, ".flush_cnt"}, n_vec, flush_cnt_o, exp_f);
         end
      end
   end

   initial begin
      rst_ni = 1'b0;
      id_rs1_addr_i = '0; id_rs1_re_i = 1'b0;
      id_rs2_addr_i = '0; id_rs2_re_i = 1'b0;
      exe_rd_addr_i = '0; exe_rd_we_i = 1'b0; exe_mem_re_i = 1'b0;
      exe_branch_taken_i = 1'b0; dmem_busy_i = 1'b0;

      //   name        rst rs1 re rs2 re rd we ld br bsy modes  to stall flush chk
      add("rst_all",    0,  5, 1, 5, 1, 5, 1, 1, 1, 1, M_RST,  0,  0, 0, 0);
      add("rst_all",    0,  5, 1, 5, 1, 5, 1, 1, 1, 1, M_RST,  0,  0, 0, 1);
      add("release",    1,  0, 0, 0, 0, 0, 0, 0, 0, 0, M_IDLE, 0,  0, 0, 1);
      add("lu_rs2",     1,  3, 1, 5, 1, 5, 1, 1, 0, 0, M_LU,   0,  0, 0, 1);
      add("lu_bubble",  1,  3, 1, 5, 1, 5, 0, 0, 0, 0, M_IDLE, 0,  1, 0, 1);
      add("lu_x0",      1,  0, 1, 0, 1, 0, 1, 1, 0, 0, M_IDLE, 0,  1, 0, 1);
      add("lu_re_off",  1,  7, 0, 2, 1, 7, 1, 1, 0, 0, M_IDLE, 0,  1, 0, 1);
      add("lu_rs1",     1,  9, 1, 0, 0, 9, 1, 1, 0, 0, M_LU,   0,  1, 0, 1);
      add("no_load",    1,  9, 1, 0, 0, 9, 1, 0, 0, 0, M_IDLE, 0,  2, 0, 1);
      add("br_lu",      1,  0, 0, 5, 1, 5, 1, 1, 1, 0, M_BR,   0,  2, 0, 1);
      add("idle_a",     1,  0, 0, 0, 0, 0, 0, 0, 0, 0, M_IDLE, 0,  2, 1, 1);
      for (int i = 0; i < 3; i++)
         add("busy_br", 1,  0, 0, 0, 0, 0, 0, 0, 1, 1, M_MW,   0,  2 + i, 1, 1);
      add("br_after",   1,  0, 0, 0, 0, 0, 0, 0, 1, 0, M_BR,   0,  5, 1, 1);
      add("idle_b",     1,  0, 0, 0, 0, 0, 0, 0, 0, 0, M_IDLE, 0,  5, 2, 1);
      for (int i = 0; i < 3; i++)
         add("busy_a",  1,  0, 0, 0, 0, 0, 0, 0, 0, 1, M_MW,   0,  5 + i, 2, 1);
      add("busy_gap",   1,  0, 0, 0, 0, 0, 0, 0, 0, 0, M_IDLE, 0,  8, 2, 1);
      for (int i = 0; i < 6; i++)
         add("busy_b",  1,  0, 0, 0, 0, 0, 0, 0, 0, 1, M_MW,   (i >= 4), 8 + i, 2, 1);
      add("busy_drop",  1,  0, 0, 0, 0, 0, 0, 0, 0, 0, M_IDLE, 1, 14, 2, 1);
      add("sticky",     1,  0, 0, 0, 0, 0, 0, 0, 0, 1, M_MW,   1, 14, 2, 1);
      add("rst_mid",    0,  5, 1, 5, 1, 5, 1, 1, 1, 1, M_RST,  1, 15, 2, 1);
      add("rel_busy",   1,  0, 0, 0, 0, 0, 0, 0, 0, 1, M_MW,   0,  0, 0, 1);
      add("rel_idle",   1,  0, 0, 0, 0, 0, 0, 0, 0, 0, M_IDLE, 0,  1, 0, 1);
      add("rel_idle",   1,  0, 0, 0, 0, 0, 0, 0, 0, 0, M_IDLE, 0,  1, 0, 1);

      foreach (vecs[k]) begin
         @(posedge clk_i);
         #1;
         rst_ni             = vecs[k].rst_n;
         id_rs1_addr_i      = vecs[k].rs1;
         id_rs1_re_i        = vecs[k].re1;
         id_rs2_addr_i      = vecs[k].rs2;
         id_rs2_re_i        = vecs[k].re2;
         exe_rd_addr_i      = vecs[k].rd;
         exe_rd_we_i        = vecs[k].we;
         exe_mem_re_i       = vecs[k].ld;
         exe_branch_taken_i = vecs[k].br;
         dmem_busy_i        = vecs[k].busy;
         sb.push_back(vecs[k]);
      end

      for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk_i);
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL drain: got %0d pending entries expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
